// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, column drive
// patterns, key-code width and small encode helpers.
package keypad_scan_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0] COL_DRV_0 = 4'b1110;
  localparam logic [3:0] COL_DRV_1 = 4'b1101;
  localparam logic [3:0] COL_DRV_2 = 4'b1011;
  localparam logic [3:0] COL_DRV_3 = 4'b0111;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drv;
    case (idx)
      2'd0:    drv = COL_DRV_0;
      2'd1:    drv = COL_DRV_1;
      2'd2:    drv = COL_DRV_2;
      default: drv = COL_DRV_3;
    endcase
    return drv;
  endfunction

  // Rows are active-low; the lowest-index asserted row wins on multi-press.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] r;
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else               r = 2'd3;
    return r;
  endfunction

  // row*4+col is just the concatenation for a 4-column matrix.
  function automatic logic [KEY_W-1:0] key_encode(input logic [1:0] row,
                                                  input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Consecutive-sample counter: done rises on the sample that completes
// DEBOUNCE_CNT matches in a row; the count saturates and clears on request.
module keypad_debounce #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic match,
  input  logic clear,
  output logic done
);

  localparam int CW = (DEBOUNCE_CNT < 1) ? 1 : $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !match) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Combinational so the owning FSM can leave on the completing sample itself.
  assign done = match && (cnt_q >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-clock
// key_valid strobe. Optional auto-repeat is enabled by KEYPAD_SCAN_REPEAT_EN.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_CNT   = 64
) (
  input  logic             Keypad_clk,
  input  logic             reset,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic [1:0]       dbg_state_o
);

  if (REPEAT_CNT < 2) begin : g_bad_repeat_cnt
    $error("keypad_scan: REPEAT_CNT must be at least 2");
  end

  kp_state_e        state_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       row_q;
  logic             phase_q;
  logic [3:0]       col_out_q;
  logic [KEY_W-1:0] key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic       rows_idle;
  logic [1:0] col_next;
  logic       db_match;
  logic       db_clear;
  logic       db_done;
  logic       rpt_fire;

  assign rows_idle = (row_in == 4'hF);
  assign col_next  = col_idx_q + 2'd1;

  // Debounce only runs in DEBOUNCE and RELEASE; leaving either state or
  // losing the match clears it, so every state change starts from zero.
  always_comb begin
    db_match = 1'b0;
    db_clear = 1'b1;
    case (state_q)
      ST_DEBOUNCE: begin
        db_match = ~row_in[row_q];
        db_clear = ~db_match | db_done;
      end
      ST_RELEASE: begin
        db_match = rows_idle;
        db_clear = ~db_match | db_done;
      end
      default: begin
        db_match = 1'b0;
        db_clear = 1'b1;
      end
    endcase
  end

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk  (Keypad_clk),
    .rst  (reset),
    .match(db_match),
    .clear(db_clear),
    .done (db_done)
  );

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT);

  logic [RW-1:0] rpt_cnt_q;

  // Held at zero outside PRESSED, so every entry starts a fresh period.
  assign rpt_fire = (state_q == ST_PRESSED) && (rpt_cnt_q == RW'(REPEAT_CNT - 1));

  always_ff @(posedge Keypad_clk or posedge reset) begin
    if (reset) begin
      rpt_cnt_q <= '0;
    end else if (state_q != ST_PRESSED || rpt_fire) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_q + RW'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge Keypad_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_q       <= 2'd0;
      phase_q     <= 1'b0;
      col_out_q   <= COL_DRV_0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            // Sample clock: either lock onto this column or move on.
            phase_q <= 1'b0;
            if (!rows_idle) begin
              row_q   <= lowest_low_row(row_in);
              state_q <= ST_DEBOUNCE;
            end else begin
              col_idx_q <= col_next;
              col_out_q <= col_drive(col_next);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!db_match) begin
            state_q   <= ST_SCAN;
            col_idx_q <= col_next;
            col_out_q <= col_drive(col_next);
          end else if (db_done) begin
            state_q     <= ST_PRESSED;
            key_code_q  <= key_encode(row_q, col_idx_q);
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
          end
        end
        ST_PRESSED: begin
          if (rows_idle) begin
            state_q <= ST_RELEASE;
          end else if (rpt_fire) begin
            key_valid_q <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!db_match) begin
            state_q <= ST_PRESSED;
          end else if (db_done) begin
            state_q    <= ST_SCAN;
            key_held_q <= 1'b0;
            col_idx_q  <= col_next;
            col_out_q  <= col_drive(col_next);
          end
        end
        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign col_out     = col_out_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a behavioural key matrix drives row_in from
// col_out, reported key codes are scoreboarded against hand-computed values.
module tb_keypad_scan;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   row_in;
  logic [3:0]   col_out;
  logic [W-1:0] key_code;
  logic         key_valid;
  logic         key_held;
  logic [1:0]   dbg_state;

  logic [15:0]  keys;
  logic [3:0]   glitch_low;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  int n_cmp;
  int n_bad;
  int held_falls;
  logic held_prev;

  keypad_scan dut (
    .Keypad_clk (clk),
    .reset      (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared=%0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // Key matrix: a pressed key (r,c) pulls row r low while column c is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
    row_in = row_in & ~glitch_low;
  end

  // Monitor: collect every reported key and count key_held falling edges.
  initial held_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && key_valid) obs_q.push_back(key_code);
    if (held_prev && !key_held) held_falls++;
    held_prev = key_held;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] target, input string tag);
    for (int i = 0; i < 24; i++) begin
      if (col_out == target) break;
      @(negedge clk);
    end
    check_eq(tag, col_out, target);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_valid) break;
    end
    check_eq(tag, key_valid, 1);
  endtask

  task automatic score(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("%s_code%0d", tag, i), obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [3:0] scan_exp [8];
    int falls_base;

    n_cmp      = 0;
    n_bad      = 0;
    held_falls = 0;
    keys       = '0;
    glitch_low = '0;
    rst        = 1'b1;
    scan_exp   = '{4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};

    // Reset state
    tick(3);
    check_eq("rst_col", col_out, 4'hE);
    check_eq("rst_code", key_code, 0);
    check_eq("rst_valid", key_valid, 0);
    check_eq("rst_held", key_held, 0);
    check_eq("rst_state", dbg_state, 0);
    rst = 1'b0;

    // Column order, two clocks per column, wrapping 3 -> 0
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_eq($sformatf("scan_col%0d", i), col_out, scan_exp[i]);
    end

    // Key (2,1) held 20 clocks, held drops DEBOUNCE_CNT+1 clocks after release
    exp_q.push_back(4'd9);
    keys[9] = 1'b1;
    tick(20);
    check_eq("k9_held", key_held, 1);
    keys = '0;
    tick(4);
    check_eq("k9_held_rel4", key_held, 1);
    tick(1);
    check_eq("k9_held_rel5", key_held, 0);
    score("k9");

    // Two-clock glitch on row 0 while column 3 is sampled
    wait_col(4'h7, "glitch_wait");
    tick(1);
    glitch_low = 4'b0001;
    tick(1);
    check_eq("glitch_col_hold", col_out, 4'h7);
    check_eq("glitch_in_deb", dbg_state, 1);
    tick(1);
    glitch_low = 4'b0000;
    tick(1);
    check_eq("glitch_col_next", col_out, 4'hE);
    check_eq("glitch_state", dbg_state, 0);
    check_eq("glitch_held", key_held, 0);
    tick(4);
    score("glitch");

    // Release bounce: high 2 clocks, low 1 clock, then high
    exp_q.push_back(4'd2);
    falls_base = held_falls;
    keys[2] = 1'b1;
    tick(20);
    check_eq("bounce_held", key_held, 1);
    keys[2] = 1'b0;
    tick(2);
    check_eq("bounce_in_rel", dbg_state, 3);
    keys[2] = 1'b1;
    tick(1);
    check_eq("bounce_back", dbg_state, 2);
    check_eq("bounce_held2", key_held, 1);
    keys[2] = 1'b0;
    tick(8);
    check_eq("bounce_state", dbg_state, 0);
    check_eq("bounce_held3", key_held, 0);
    check_eq("bounce_falls", held_falls - falls_base, 1);
    score("bounce");

    // Keys (1,0) and (3,0) together: lowest row wins
    exp_q.push_back(4'd4);
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    tick(20);
    check_eq("multi_held", key_held, 1);
    keys = '0;
    tick(8);
    score("multi");

    // Reset during DEBOUNCE of key 15, key still held afterwards
    exp_q.push_back(4'd15);
    wait_col(4'hE, "rst_wait0");
    keys[15] = 1'b1;
    wait_col(4'h7, "rst_wait3");
    tick(2);
    check_eq("rst_in_deb", dbg_state, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_col", col_out, 4'hE);
    check_eq("midrst_code", key_code, 0);
    check_eq("midrst_valid", key_valid, 0);
    check_eq("midrst_held", key_held, 0);
    tick(2);
    rst = 1'b0;
    tick(30);
    check_eq("rst_k15_held", key_held, 1);
    keys = '0;
    tick(8);
    score("rst_k15");

    // Key 5 held 200 clocks after acceptance
    exp_q.push_back(4'd5);
`ifdef KEYPAD_SCAN_REPEAT_EN
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd5);
`endif
    keys[5] = 1'b1;
    wait_valid("rpt_wait");
    tick(200);
    check_eq("rpt_held", key_held, 1);
    keys = '0;
    tick(8);
    check_eq("rpt_idle", dbg_state, 0);
    score("rpt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive matching samples (clocks) required to accept a press or a release.
REQ-002 SHALL have parameter REPEAT_CNT, default 64: auto-repeat period in clocks; used only under KEYPAD_SCAN_REPEAT_EN.
REQ-003 SHALL have port Keypad_clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port row_in  input  4: matrix rows, active-low (pulled up), synchronous to Keypad_clk.
REQ-006 SHALL have port col_out  output  4: column drive, one-cold active-low.
REQ-007 SHALL have port key_code  output  4: accepted key, encoded as row*4+col.
REQ-008 SHALL have port key_valid  output  1: one-clock pulse when key_code is updated.
REQ-009 SHALL have port key_held  output  1: high while the accepted key remains pressed.

Function
REQ-010 SHALL implement states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-011 In SCAN, each column SHALL be driven for 2 clocks (drive, then sample), in the order col 0,1,2,3, wrapping from 3 to 0.
REQ-012 In SCAN on the sample clock with row_in != 4'b1111, the block SHALL capture col_idx and the lowest-index low row, hold the column and enter DEBOUNCE.
REQ-013 In DEBOUNCE, row_in SHALL be compared every clock; DEBOUNCE_CNT consecutive clocks with the captured row low SHALL enter PRESSED.
REQ-014 Any DEBOUNCE sample with the captured row high SHALL return to SCAN at the next column, with no output change.
REQ-015 On entry to PRESSED, key_code SHALL load row*4+col and key_valid SHALL pulse high for exactly that clock.
REQ-016 key_held SHALL be high in PRESSED and RELEASE and low otherwise.
REQ-017 In PRESSED, the column SHALL stay driven; row_in == 4'b1111 SHALL enter RELEASE.
REQ-018 In RELEASE, DEBOUNCE_CNT consecutive all-high clocks SHALL enter SCAN at the next column; any low row SHALL return to PRESSED with no new key_valid.
REQ-019 When several keys are pressed, only the first accepted key SHALL be reported; no second key is reported until release completes.
REQ-020 The debounce counter SHALL saturate at DEBOUNCE_CNT and SHALL be cleared on every state change.

Reset
REQ-021 On reset assertion the block SHALL asynchronously enter SCAN with col_idx=0, col_out=4'b1110, key_code=4'd0, key_valid=0, key_held=0, and all counters cleared.
REQ-022 Reset asserted mid-press SHALL suppress any pending key_valid; after deassertion, a still-held key SHALL be re-debounced and reported once.

Configuration
REQ-023 With KEYPAD_SCAN_REPEAT_EN defined, key_valid SHALL re-pulse every REPEAT_CNT clocks while in PRESSED, with the same key_code, and the repeat counter SHALL be cleared on entry to PRESSED.
REQ-024 Without KEYPAD_SCAN_REPEAT_EN, key_valid SHALL pulse once per press and the repeat logic SHALL be absent.

Structure
REQ-025 A shared package SHALL hold the state encoding, the column one-cold constants (4'b1110, 4'b1101, 4'b1011, 4'b0111) and the key-code width.
REQ-026 Debounce counting SHALL be a sub-module keypad_debounce (inputs: match, clear; output: done at DEBOUNCE_CNT).

Verification
REQ-027 Key row 2, col 1 held 20 clocks -> single key_valid with key_code=4'd9, key_held high until release + DEBOUNCE_CNT clocks.
REQ-028 Glitch: row 0 low for 2 clocks during col 3 sample -> no key_valid; scanning resumes at col 0.
REQ-029 Bounce on release: row high 2 clocks, low 1 clock, then high -> no second key_valid, single return to SCAN.
REQ-030 Keys (1,0) and (3,0) pressed together -> key_code=4'd4 only.
REQ-031 Reset asserted during DEBOUNCE of key 4'd15 -> outputs zero immediately; key still held after deassertion -> one key_valid with 4'd15.
REQ-032 With KEYPAD_SCAN_REPEAT_EN and REPEAT_CNT=64, key 4'd5 held 200 clocks after acceptance -> 4 key_valid pulses total (initial + 3 repeats).
